// File: rtl/controle_pc_pkg.sv
// rtl/controle_pc_pkg.sv - shared states, branch-type codes and default width for the PC sequencer
package pc_pkg;

    localparam int LARGURA_PADRAO = 32;

    typedef enum logic [2:0] {
        INICIO,
        BUSCA,
        EXECUTA,
        PARADO,
        ERRO
    } estado_t;

    localparam logic [2:0] DESVIO_INCOND = 3'd0;
    localparam logic [2:0] BEQ           = 3'd1;
    localparam logic [2:0] BNE           = 3'd2;
    localparam logic [2:0] BLT           = 3'd3;
    localparam logic [2:0] BGE           = 3'd4;
    localparam logic [2:0] JAL           = 3'd6;
    localparam logic [2:0] JR            = 3'd7;

endpackage

// File: rtl/controle_pc_if.sv
// rtl/controle_pc_if.sv - fetch handshake, execute-completion inputs and status outputs of the PC sequencer
interface controle_pc_if #(
    parameter int LARGURA = 32
);
    logic [LARGURA-1:0] pc;
    logic               busca_req;
    logic               busca_ack;
    logic               exec_valido;
    logic               PCSrc;
    logic [2:0]         tipo_branch;
    logic [LARGURA-1:0] imed;
    logic [LARGURA-1:0] rl2out;
    logic               neg;
    logic               zero;
    logic               parar;
    logic [LARGURA-1:0] link;
    logic               retirada;
    logic               parado;
    logic               erro;

    modport master (
        output pc, busca_req, link, retirada, parado, erro,
        input  busca_ack, exec_valido, PCSrc, tipo_branch, imed, rl2out, neg, zero, parar
    );

    modport slave (
        input  pc, busca_req, link, retirada, parado, erro,
        output busca_ack, exec_valido, PCSrc, tipo_branch, imed, rl2out, neg, zero, parar
    );
endinterface

// File: rtl/controle_pc_avalia_desvio.sv
// rtl/controle_pc_avalia_desvio.sv - combinational next-PC and taken evaluation for the current instruction
module avalia_desvio
    import pc_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic [LARGURA-1:0] pc,
    input  logic               PCSrc,
    input  logic [2:0]         tipo_branch,
    input  logic [LARGURA-1:0] imed,
    input  logic [LARGURA-1:0] rl2out,
    input  logic               neg,
    input  logic               zero,
    output logic [LARGURA-1:0] novo_pc,
    output logic               tomado
);

    logic               condicao;
    logic [LARGURA-1:0] alvo;

    always_comb begin
        condicao = 1'b1;
        case (tipo_branch)
            BEQ:     condicao = zero;
            BNE:     condicao = !zero;
            BLT:     condicao = neg;
            BGE:     condicao = zero | !neg;
            default: condicao = 1'b1;
        endcase
    end

    // jr is absolute; every other taken transfer is PC-relative and may wrap
    assign alvo    = (tipo_branch == JR) ? rl2out : pc + imed;
    assign tomado  = PCSrc & condicao;
    assign novo_pc = tomado ? alvo : pc + LARGURA'(1);

endmodule

// File: rtl/controle_pc.sv
// rtl/controle_pc.sv - multi-cycle PC sequencer with fetch handshake; optional CONTADORES_DESEMPENHO_EN counters
module controle_pc
    import pc_pkg::*;
#(
    parameter int LARGURA    = LARGURA_PADRAO,
    parameter int PC_INICIAL = 0,
    parameter int MAX_ESPERA = 15
) (
    input  logic          clock,
    input  logic          reset_n,
    controle_pc_if.master bus
`ifdef CONTADORES_DESEMPENHO_EN
    ,
    output logic [31:0]   cont_instr,
    output logic [31:0]   cont_desvios
`endif
);

    localparam int LE = $clog2(MAX_ESPERA + 1);

    estado_t            estado, estado_prox;
    logic [LARGURA-1:0] pc_r, link_r, novo_pc;
    logic [LE-1:0]      espera;
    logic               tomado;
    logic               carrega_pc, retira, espera_limpa, espera_inc;
    logic               retirada_r;

    avalia_desvio #(.LARGURA(LARGURA)) u_avalia (
        .pc          (pc_r),
        .PCSrc       (bus.PCSrc),
        .tipo_branch (bus.tipo_branch),
        .imed        (bus.imed),
        .rl2out      (bus.rl2out),
        .neg         (bus.neg),
        .zero        (bus.zero),
        .novo_pc     (novo_pc),
        .tomado      (tomado)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) estado <= INICIO;
        else          estado <= estado_prox;
    end

    always_comb begin
        estado_prox  = estado;
        carrega_pc   = 1'b0;
        retira       = 1'b0;
        espera_limpa = 1'b0;
        espera_inc   = 1'b0;
        case (estado)
            INICIO: begin
                estado_prox  = BUSCA;
                espera_limpa = 1'b1;
            end
            BUSCA: begin
                if (bus.busca_ack)                        estado_prox = EXECUTA;
                else if (espera == LE'(MAX_ESPERA - 1))   estado_prox = ERRO;
                else                                      espera_inc  = 1'b1;
            end
            EXECUTA: begin
                if (bus.exec_valido) begin
                    retira = 1'b1;
                    // halt wins over any control transfer in the same instruction
                    if (bus.parar) begin
                        estado_prox = PARADO;
                    end else begin
                        estado_prox  = BUSCA;
                        carrega_pc   = 1'b1;
                        espera_limpa = 1'b1;
                    end
                end
            end
            PARADO:  estado_prox = PARADO;
            ERRO:    estado_prox = ERRO;
            default: estado_prox = INICIO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_r       <= LARGURA'(PC_INICIAL);
            link_r     <= '0;
            espera     <= '0;
            retirada_r <= 1'b0;
        end else begin
            retirada_r <= retira;
            if (espera_limpa)    espera <= '0;
            else if (espera_inc) espera <= espera + LE'(1);
            if (carrega_pc) begin
                pc_r <= novo_pc;
                if (bus.PCSrc && bus.tipo_branch == JAL) link_r <= pc_r + LARGURA'(1);
            end
        end
    end

`ifdef CONTADORES_DESEMPENHO_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cont_instr   <= '0;
            cont_desvios <= '0;
        end else begin
            if (retira)                cont_instr   <= cont_instr + 32'd1;
            if (carrega_pc && tomado)  cont_desvios <= cont_desvios + 32'd1;
        end
    end
`endif

    assign bus.pc        = pc_r;
    assign bus.link      = link_r;
    assign bus.retirada  = retirada_r;
    assign bus.busca_req = (estado == BUSCA);
    assign bus.parado    = (estado == PARADO);
    assign bus.erro      = (estado == ERRO);

endmodule

// File: tb/tb_controle_pc.sv
// tb/tb_controle_pc.sv - directed scoreboard bench for controle_pc
module tb_controle_pc;
    import pc_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    controle_pc_if #(.LARGURA(32)) bus ();

`ifdef CONTADORES_DESEMPENHO_EN
    logic [31:0] cont_instr, cont_desvios;
`endif

    controle_pc #(.LARGURA(32), .PC_INICIAL(0), .MAX_ESPERA(15)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef CONTADORES_DESEMPENHO_EN
        ,
        .cont_instr   (cont_instr),
        .cont_desvios (cont_desvios)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] link;
    } esperado_t;

    esperado_t sb[$];
    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic buscar();
        int t = 0;
        while (bus.busca_req !== 1'b1 && t < 50) begin
            @(negedge clock);
            t++;
        end
        chk1("busca_req_wait", bus.busca_req, 1'b1);
        bus.busca_ack = 1'b1;
        @(negedge clock);
        bus.busca_ack = 1'b0;
        chk1("busca_req_drop", bus.busca_req, 1'b0);
        chk1("retirada_idle", bus.retirada, 1'b0);
    endtask

    task automatic executar(input logic pcsrc, input logic [2:0] tipo, input logic [31:0] imed,
                            input logic [31:0] rl2, input logic neg, input logic zero,
                            input logic parar, input logic [31:0] exp_pc, input logic [31:0] exp_link);
        esperado_t e;
        bus.PCSrc       = pcsrc;
        bus.tipo_branch = tipo;
        bus.imed        = imed;
        bus.rl2out      = rl2;
        bus.neg         = neg;
        bus.zero        = zero;
        bus.parar       = parar;
        bus.exec_valido = 1'b1;
        e.pc   = exp_pc;
        e.link = exp_link;
        sb.push_back(e);
        @(negedge clock);
        bus.exec_valido = 1'b0;
        bus.parar       = 1'b0;
        bus.PCSrc       = 1'b0;
        chk1("retirada", bus.retirada, 1'b1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc", bus.pc, e.pc);
            chk("link", bus.link, e.link);
        end
        chk1("busca_req_next", bus.busca_req, !parar);
    endtask

    task automatic passo(input logic pcsrc, input logic [2:0] tipo, input logic [31:0] imed,
                         input logic [31:0] rl2, input logic neg, input logic zero,
                         input logic [31:0] exp_pc, input logic [31:0] exp_link);
        buscar();
        executar(pcsrc, tipo, imed, rl2, neg, zero, 1'b0, exp_pc, exp_link);
    endtask

    task automatic pulsa_reset();
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        bus.busca_ack = 1'b0; bus.exec_valido = 1'b0; bus.PCSrc = 1'b0;
        bus.tipo_branch = 3'd0; bus.imed = '0; bus.rl2out = '0;
        bus.neg = 1'b0; bus.zero = 1'b0; bus.parar = 1'b0;

        repeat (2) @(negedge clock);
        chk("reset_pc", bus.pc, 32'd0);
        chk("reset_link", bus.link, 32'd0);
        chk1("reset_busca_req", bus.busca_req, 1'b0);
        chk1("reset_retirada", bus.retirada, 1'b0);
        chk1("reset_parado", bus.parado, 1'b0);
        chk1("reset_erro", bus.erro, 1'b0);
        reset_n = 1'b1;
        @(negedge clock);
        chk1("first_busca_req", bus.busca_req, 1'b1);

        passo(1'b0, DESVIO_INCOND, 32'd0, 32'd0, 1'b0, 1'b0, 32'd1, 32'd0);
        passo(1'b0, DESVIO_INCOND, 32'd0, 32'd0, 1'b0, 1'b0, 32'd2, 32'd0);
        passo(1'b0, DESVIO_INCOND, 32'd0, 32'd0, 1'b0, 1'b0, 32'd3, 32'd0);

        buscar();
        repeat (2) begin
            @(negedge clock);
            chk1("wait_exec_retirada", bus.retirada, 1'b0);
            chk("wait_exec_pc", bus.pc, 32'd3);
        end
        executar(1'b1, JR, 32'd0, 32'd10, 1'b0, 1'b0, 1'b0, 32'd10, 32'd0);

        passo(1'b1, BEQ, -32'sd4, 32'd0, 1'b0, 1'b1, 32'd6, 32'd0);
        passo(1'b1, JR, 32'd0, 32'd10, 1'b0, 1'b0, 32'd10, 32'd0);
        passo(1'b1, BEQ, -32'sd4, 32'd0, 1'b0, 1'b0, 32'd11, 32'd0);
        passo(1'b1, JR, 32'd0, 32'd20, 1'b0, 1'b0, 32'd20, 32'd0);
        passo(1'b1, BGE, 32'd7, 32'd0, 1'b1, 1'b0, 32'd21, 32'd0);
        passo(1'b1, JR, 32'd0, 32'd20, 1'b0, 1'b0, 32'd20, 32'd0);
        passo(1'b1, BLT, 32'd5, 32'd0, 1'b1, 1'b0, 32'd25, 32'd0);
        passo(1'b1, JR, 32'd0, 32'd8, 1'b0, 1'b0, 32'd8, 32'd0);
        passo(1'b1, JAL, 32'd100, 32'd0, 1'b0, 1'b0, 32'd108, 32'd9);
        passo(1'b1, JR, 32'd0, 32'd9, 1'b0, 1'b0, 32'd9, 32'd9);
        passo(1'b1, BNE, 32'd3, 32'd0, 1'b0, 1'b0, 32'd12, 32'd9);
        passo(1'b1, 3'd5, 32'd2, 32'd0, 1'b0, 1'b0, 32'd14, 32'd9);
        passo(1'b1, JR, 32'd0, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd9);
        passo(1'b1, DESVIO_INCOND, 32'd4, 32'd0, 1'b0, 1'b0, 32'd2, 32'd9);

        repeat (14) @(negedge clock);
        chk1("timeout_edge_req", bus.busca_req, 1'b1);
        chk1("timeout_edge_erro", bus.erro, 1'b0);
        @(negedge clock);
        chk1("timeout_erro", bus.erro, 1'b1);
        chk1("timeout_req_low", bus.busca_req, 1'b0);
        chk("timeout_pc", bus.pc, 32'd2);
        bus.busca_ack = 1'b1;
        repeat (2) @(negedge clock);
        bus.busca_ack = 1'b0;
        chk1("erro_sticky", bus.erro, 1'b1);
        chk("erro_pc_frozen", bus.pc, 32'd2);
        pulsa_reset();
        chk1("erro_cleared", bus.erro, 1'b0);
        chk("erro_reset_pc", bus.pc, 32'd0);
        chk("erro_reset_link", bus.link, 32'd0);
        chk1("erro_reset_req", bus.busca_req, 1'b0);

        passo(1'b0, DESVIO_INCOND, 32'd0, 32'd0, 1'b0, 1'b0, 32'd1, 32'd0);
        buscar();
        executar(1'b1, JAL, 32'd50, 32'd0, 1'b0, 1'b0, 1'b1, 32'd1, 32'd0);
        chk1("parado_set", bus.parado, 1'b1);
        bus.busca_ack = 1'b1;
        bus.exec_valido = 1'b1;
        repeat (4) begin
            @(negedge clock);
            chk1("parado_no_req", bus.busca_req, 1'b0);
            chk1("parado_hold", bus.parado, 1'b1);
        end
        bus.busca_ack = 1'b0;
        bus.exec_valido = 1'b0;
        chk("parado_pc", bus.pc, 32'd1);
        chk1("parado_no_retire", bus.retirada, 1'b0);

`ifdef CONTADORES_DESEMPENHO_EN
        pulsa_reset();
        chk("cont_instr_reset", cont_instr, 32'd0);
        passo(1'b0, DESVIO_INCOND, 32'd0, 32'd0, 1'b0, 1'b0, 32'd1, 32'd0);
        passo(1'b1, JAL, 32'd10, 32'd0, 1'b0, 1'b0, 32'd11, 32'd2);
        passo(1'b1, BNE, 32'd5, 32'd0, 1'b0, 1'b1, 32'd12, 32'd2);
        passo(1'b1, DESVIO_INCOND, -32'sd12, 32'd0, 1'b0, 1'b0, 32'd0, 32'd2);
        chk("cont_instr", cont_instr, 32'd4);
        chk("cont_desvios", cont_desvios, 32'd2);
        buscar();
        pulsa_reset();
        chk("cont_instr_midexec", cont_instr, 32'd0);
        chk("cont_desvios_midexec", cont_desvios, 32'd0);
        chk("midexec_pc", bus.pc, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
